// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: fetch PC sequencer merging I-cache hits and branch predictions into the fetch buffer
module if_fetch_ctrl #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] HALT_INSN = 32'h0000_0555
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_en_i,
    input  logic [63:0] flush_PC_i,
    input  logic        ifb_full_i,
    input  logic        ic_hit_i,
    input  logic [63:0] ic_data_i,
    input  logic        bp_taken_i,
    input  logic [63:0] bp_target_i,
    output logic        ic_req_o,
    output logic [63:0] ic_addr_o,
    output logic [63:0] bp_PC_o,
    output logic        ifb_en_o,
    output logic [31:0] if_insn_o,
    output logic [63:0] if_PC_o,
    output logic [63:0] if_target_PC_o,
    output logic        if_pred_bit_o,
    output logic        fetch_halted_o
);
    typedef enum logic [1:0] {RUN, MISS, HALTED} state_t;

    state_t      state_q;
    logic [63:0] pc_q;
    logic [31:0] insn;
    logic [63:0] target;
    logic        fetching;
    logic        accept;

    assign insn     = pc_q[2] ? ic_data_i[63:32] : ic_data_i[31:0];
    assign target   = bp_taken_i ? bp_target_i : pc_q + 64'd4;
    assign fetching = state_q != HALTED;
    // a flush in the same cycle as a hit must not enqueue the stale-path word
    assign accept   = fetching & ic_hit_i & ~ifb_full_i & ~flush_en_i;

    // outputs are forced quiet while reset is held
    always_comb begin
        ic_req_o       = ~rst & fetching;
        ic_addr_o      = rst ? 64'h0 : {pc_q[63:3], 3'b000};
        bp_PC_o        = rst ? 64'h0 : pc_q;
        if_PC_o        = rst ? 64'h0 : pc_q;
        if_insn_o      = rst ? 32'h0 : insn;
        if_target_PC_o = rst ? 64'h0 : target;
        if_pred_bit_o  = ~rst & bp_taken_i;
        ifb_en_o       = ~rst & accept;
        fetch_halted_o = ~rst & (state_q == HALTED);
    end

    // fetch FSM: reset, then flush, then hit/miss/full sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else if (flush_en_i) begin
            pc_q    <= flush_PC_i & ~64'h3;
            state_q <= RUN;
        end else if (fetching) begin
            if (accept) begin
                pc_q    <= target;
                state_q <= (insn == HALT_INSN) ? HALTED : RUN;
            end else begin
                state_q <= ic_hit_i ? RUN : MISS;
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed self-checking bench for the fetch sequencer
module tb_if_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst, flush_en, ifb_full, ic_hit, bp_taken;
    logic [63:0] flush_pc, ic_data, bp_target;
    logic        ic_req, ifb_en, pred_bit, halted;
    logic [63:0] ic_addr, bp_pc, if_pc, if_target;
    logic [31:0] if_insn;
    int          n_cmp = 0;
    int          n_err = 0;

    if_fetch_ctrl #(.RESET_PC(64'h100)) dut (
        .clk(clk), .rst(rst), .flush_en_i(flush_en), .flush_PC_i(flush_pc),
        .ifb_full_i(ifb_full), .ic_hit_i(ic_hit), .ic_data_i(ic_data),
        .bp_taken_i(bp_taken), .bp_target_i(bp_target),
        .ic_req_o(ic_req), .ic_addr_o(ic_addr), .bp_PC_o(bp_pc),
        .ifb_en_o(ifb_en), .if_insn_o(if_insn), .if_PC_o(if_pc),
        .if_target_PC_o(if_target), .if_pred_bit_o(pred_bit),
        .fetch_halted_o(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // apply one cycle of inputs in the low phase and let outputs settle
    task automatic drv(input logic r, input logic fl, input logic [63:0] fpc,
                       input logic hit, input logic full, input logic tk,
                       input logic [63:0] tgt, input logic [63:0] data);
        @(negedge clk);
        rst = r; flush_en = fl; flush_pc = fpc; ic_hit = hit; ifb_full = full;
        bp_taken = tk; bp_target = tgt; ic_data = data;
        #1;
    endtask

    initial begin
        rst = 1; flush_en = 0; flush_pc = 0; ic_hit = 0; ifb_full = 0;
        bp_taken = 0; bp_target = 0; ic_data = 0;
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 64'h999, 1, 0, 1, 64'h777, 64'h1234);
        chk("rst_req", ic_req, 0);
        chk("rst_en", ifb_en, 0);
        chk("rst_addr", ic_addr, 0);
        chk("rst_halt", halted, 0);
        chk("rst_pred", pred_bit, 0);
        // sequential fetch 0x100..0x10C
        drv(0, 0, 0, 1, 0, 0, 0, 64'hBBBB0001_AAAA0001);
        chk("c1_addr", ic_addr, 64'h100);
        chk("c1_pc", if_pc, 64'h100);
        chk("c1_bppc", bp_pc, 64'h100);
        chk("c1_en", ifb_en, 1);
        chk("c1_insn", if_insn, 32'hAAAA0001);
        chk("c1_tgt", if_target, 64'h104);
        drv(0, 0, 0, 1, 0, 0, 0, 64'hBBBB0001_AAAA0001);
        chk("c2_pc", if_pc, 64'h104);
        chk("c2_insn", if_insn, 32'hBBBB0001);
        chk("c2_en", ifb_en, 1);
        drv(0, 0, 0, 1, 0, 0, 0, 64'hDDDD0002_CCCC0002);
        chk("c3_pc", if_pc, 64'h108);
        chk("c3_insn", if_insn, 32'hCCCC0002);
        drv(0, 0, 0, 1, 0, 0, 0, 64'hDDDD0002_CCCC0002);
        chk("c4_pc", if_pc, 64'h10C);
        chk("c4_addr", ic_addr, 64'h108);
        chk("c4_insn", if_insn, 32'hDDDD0002);
        chk("c4_en", ifb_en, 1);
        // flush during RUN with a hit, misaligned target truncated to 0x104
        drv(0, 1, 64'h107, 1, 0, 0, 0, 64'h0);
        chk("fl_run_en", ifb_en, 0);
        // predicted taken at 0x104 -> 0x200, then back-to-back taken
        drv(0, 0, 0, 1, 0, 1, 64'h200, 64'hBBBB0001_AAAA0001);
        chk("tk_pc", if_pc, 64'h104);
        chk("tk_tgt", if_target, 64'h200);
        chk("tk_pred", pred_bit, 1);
        chk("tk_en", ifb_en, 1);
        drv(0, 0, 0, 1, 0, 1, 64'h108, 64'h0);
        chk("tk2_pc", if_pc, 64'h200);
        chk("tk2_en", ifb_en, 1);
        // miss at 0x108 for 3 cycles then hit, predicted to 0x300
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 64'h0);
            chk("miss_addr", ic_addr, 64'h108);
            chk("miss_req", ic_req, 1);
            chk("miss_en", ifb_en, 0);
        end
        drv(0, 0, 0, 1, 0, 1, 64'h300, 64'h0000_0000_1234_5678);
        chk("mhit_addr", ic_addr, 64'h108);
        chk("mhit_en", ifb_en, 1);
        chk("mhit_pc", if_pc, 64'h108);
        chk("mhit_insn", if_insn, 32'h1234_5678);
        // buffer full for 2 cycles at 0x300
        for (int i = 0; i < 2; i++) begin
            drv(0, 0, 0, 1, 1, 0, 0, 64'h0);
            chk("full_pc", if_pc, 64'h300);
            chk("full_en", ifb_en, 0);
        end
        drv(0, 0, 0, 1, 0, 0, 0, 64'h0);
        chk("unfull_pc", if_pc, 64'h300);
        chk("unfull_en", ifb_en, 1);
        // miss at 0x304, then flush during MISS with a hit present
        drv(0, 0, 0, 0, 0, 0, 0, 64'h0);
        chk("m304_pc", if_pc, 64'h304);
        chk("m304_en", ifb_en, 0);
        drv(0, 1, 64'h480, 1, 0, 0, 0, 64'h0);
        chk("fl_miss_en", ifb_en, 0);
        drv(0, 0, 0, 1, 0, 1, 64'h500, 64'h0);
        chk("fl_miss_addr", ic_addr, 64'h480);
        chk("fl_miss_halt", halted, 0);
        chk("fl_miss_req", ic_req, 1);
        // halt instruction at 0x500
        drv(0, 0, 0, 1, 0, 0, 0, 64'h9999_9999_0000_0555);
        chk("halt_pc", if_pc, 64'h500);
        chk("halt_insn", if_insn, 32'h0000_0555);
        chk("halt_en", ifb_en, 1);
        chk("halt_pre", halted, 0);
        for (int i = 0; i < 2; i++) begin
            drv(0, 0, 0, 1, 0, 0, 0, 64'h0);
            chk("hlt_flag", halted, 1);
            chk("hlt_req", ic_req, 0);
            chk("hlt_en", ifb_en, 0);
        end
        // flush out of HALTED
        drv(0, 1, 64'h480, 1, 0, 0, 0, 64'h0);
        chk("fl_hlt_en", ifb_en, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 64'h0);
        chk("fl_hlt_addr", ic_addr, 64'h480);
        chk("fl_hlt_flag", halted, 0);
        chk("fl_hlt_req", ic_req, 1);
        // reset mid-miss
        drv(1, 0, 0, 0, 0, 0, 0, 64'h0);
        chk("rst2_req", ic_req, 0);
        chk("rst2_addr", ic_addr, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 64'h0);
        chk("rst2_pc", if_pc, 64'h100);
        chk("rst2_req1", ic_req, 1);
        // PC+4 wrap, misaligned flush target truncated
        drv(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 64'h0);
        drv(0, 0, 0, 1, 0, 0, 0, 64'h5555_AAAA_0000_0001);
        chk("wrap_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr", ic_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("wrap_insn", if_insn, 32'h5555_AAAA);
        chk("wrap_tgt", if_target, 64'h0);
        drv(0, 0, 0, 0, 0, 0, 0, 64'h0);
        chk("wrap_next", if_pc, 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
